sram_controller: RTL
====================

Name: sram_controller

Overview:
- Memory-stage responder for the pipeline's data memory. It accepts a 32-bit word read or write request from the MEM stage and runs it as two 16-bit accesses on the external asynchronous SRAM.
- It drives `ready`, the stall/advance signal consumed by every pipeline register including MEM/WB.
- `ready` is low while an access is in flight and high when the MEM stage may advance.

Parameters:
- ADDR_OFFSET, 1024: byte address of data-memory base; subtracted before word mapping.
- WAIT_CYCLES, 3: clock cycles each 16-bit SRAM phase is held (must be >= 1).

Ports:
- clk  input  1  clock
- rst  input  1  reset (already decided below)
- wr_en  input  1  MEM-stage store request
- rd_en  input  1  MEM-stage load request
- address  input  32  byte address from ALU result
- write_data  input  32  store data
- read_data  output  32  loaded word, registered
- ready  output  1  1 = pipeline may advance; 0 = stall
- SRAM_DQ  inout  16  SRAM data bus
- SRAM_ADDR  output  18  SRAM half-word address
- SRAM_WE_N  output  1  write enable, active low
- SRAM_OE_N  output  1  output enable, active low
- SRAM_CE_N  output  1  chip enable, tied 0
- SRAM_UB_N  output  1  upper byte enable, tied 0
- SRAM_LB_N  output  1  lower byte enable, tied 0

Behaviour:
- Reset: reset rst, asynchronous, active-high; clock clk.
  - Reset forces state=IDLE, counter=0, read_data=0, latched op/addr/data=0.
  - Reset also forces SRAM_WE_N=1, SRAM_OE_N=1 and SRAM_DQ=Z.
- FSM states: IDLE, LOW, HIGH, DONE.
- IDLE:
  - ready = ~(rd_en | wr_en), combinational.
  - On a request, latch op (write wins if both rd_en and wr_en are set), word address and write_data, then go to LOW with counter=0.
- LOW (phase 0):
  - SRAM_ADDR = {word[16:0], 1'b0}.
  - Write: SRAM_DQ = latched data[15:0], SRAM_WE_N = 0.
  - Read: SRAM_OE_N = 0, SRAM_DQ = Z.
  - Counter increments each cycle. On counter == WAIT_CYCLES-1: a read captures SRAM_DQ into read_data[15:0]; go to HIGH with counter=0.
- HIGH (phase 1): same as LOW with SRAM_ADDR = {word[16:0], 1'b1}, data[31:16], capture into read_data[31:16]; go to DONE.
- DONE: ready = 1 for exactly one cycle; SRAM_WE_N = SRAM_OE_N = 1; DQ = Z; go to IDLE unconditionally.
- ready = 0 in LOW and HIGH.
- Word mapping: word = (address - ADDR_OFFSET) >> 2, truncated to 17 bits; wrap-around is silent.
- Latency: ready is low for 1 + 2*WAIT_CYCLES cycles after a request appears, then high in DONE.
- The request is sampled only in IDLE. Changes to wr_en, rd_en, address or write_data mid-transaction are ignored.
- A back-to-back request seen in IDLE right after DONE starts a new access. ready drops in that IDLE cycle.
- read_data holds its value until the next read completes. Writes never modify it.
- SRAM_DQ is driven only in LOW and HIGH of a write; otherwise Z.
- Reset mid-operation: abort immediately; no further SRAM strobes; a partial write is not completed.

Optional Feature:
- Macro: SRAM_LAST_READ_CACHE_EN.
- Defined:
  - Keep a valid bit plus the word address of the last completed read.
  - A read in IDLE hitting that address with valid=1 goes directly IDLE->DONE without SRAM strobes. ready is low only for the IDLE cycle and read_data is unchanged.
  - Any write clears valid; reset clears valid.
- Undefined: no cache; every read takes the full latency.

Test Plan (WAIT_CYCLES=3, ADDR_OFFSET=1024, behavioural SRAM model):
- Write 0xDEADBEEF to address 1028:
  - SRAM_ADDR=2 with DQ=0xBEEF and WE_N=0 for 3 cycles, then SRAM_ADDR=3 with DQ=0xDEAD for 3 cycles.
  - ready low for 7 cycles, high in the 8th; model holds word 0xDEADBEEF.
- Read 1028 after that write: OE_N low for 6 cycles; read_data=0xDEADBEEF in the ready-high cycle; DQ never driven by the controller.
- No request: ready=1, WE_N=1, OE_N=1, DQ=Z; read_data retains its prior value across 10 idle cycles.
- rd_en=wr_en=1 with address 1032 and data 0x12345678: a write is performed (WE_N pulses, model word 2 = 0x12345678) and read_data is unchanged.
- Assert rst during the HIGH phase of a write:
  - Same cycle: WE_N=1, DQ=Z, read_data=0.
  - After release with no request: ready=1.
  - Model upper half is unchanged.
- With SRAM_LAST_READ_CACHE_EN:
  - Two consecutive reads of 1028: the second stalls exactly 1 cycle with no OE_N pulse.
  - Insert a write between them: the second read takes the full 7-cycle stall.

Source files
------------

// File: rtl/sram_controller.sv
// Runs a 32-bit MEM-stage load/store as two 16-bit accesses on an asynchronous SRAM and stalls the pipeline meanwhile.
// Optional last-read cache enabled by defining SRAM_LAST_READ_CACHE_EN.
module sram_controller #(
    parameter logic [31:0] ADDR_OFFSET = 32'd1024,
    parameter int          WAIT_CYCLES = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic        rd_en,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        ready,
    inout  wire  [15:0] SRAM_DQ,
    output logic [17:0] SRAM_ADDR,
    output logic        SRAM_WE_N,
    output logic        SRAM_OE_N,
    output logic        SRAM_CE_N,
    output logic        SRAM_UB_N,
    output logic        SRAM_LB_N
);

    localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST_COUNT = CW'(WAIT_CYCLES - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOW  = 2'd1;
    localparam logic [1:0] HIGH = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    logic [1:0]    state;
    logic [CW-1:0] counter;
    logic          op_write;
    logic [16:0]   word;
    logic [31:0]   data;

    logic [16:0] req_word;
    logic        req;
    logic        phase_end;
    logic        in_access;
    logic        cache_hit;

    assign req_word  = 17'((address - ADDR_OFFSET) >> 2);
    assign req       = rd_en | wr_en;
    assign phase_end = (counter == LAST_COUNT);
    assign in_access = (state == LOW) || (state == HIGH);

`ifdef SRAM_LAST_READ_CACHE_EN
    logic        cache_valid;
    logic [16:0] cache_word;

    assign cache_hit = rd_en & ~wr_en & cache_valid & (req_word == cache_word);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cache_valid <= 1'b0;
            cache_word  <= '0;
        end else if (state == IDLE && wr_en) begin
            cache_valid <= 1'b0;
        end else if (state == HIGH && phase_end && !op_write) begin
            cache_valid <= 1'b1;
            cache_word  <= word;
        end
    end
`else
    assign cache_hit = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            counter   <= '0;
            op_write  <= 1'b0;
            word      <= '0;
            data      <= '0;
            read_data <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        op_write <= wr_en;
                        word     <= req_word;
                        data     <= write_data;
                        counter  <= '0;
                        state    <= cache_hit ? DONE : LOW;
                    end
                end
                LOW: begin
                    if (phase_end) begin
                        if (!op_write) read_data[15:0] <= SRAM_DQ;
                        counter <= '0;
                        state   <= HIGH;
                    end else begin
                        counter <= counter + 1'b1;
                    end
                end
                HIGH: begin
                    if (phase_end) begin
                        if (!op_write) read_data[31:16] <= SRAM_DQ;
                        counter <= '0;
                        state   <= DONE;
                    end else begin
                        counter <= counter + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Strobes decode straight from registered state, so an async reset drops them in the same cycle.
    assign ready     = (state == IDLE) ? ~req : (state == DONE);
    assign SRAM_ADDR = {word, state == HIGH};
    assign SRAM_WE_N = ~(in_access & op_write);
    assign SRAM_OE_N = ~(in_access & ~op_write);
    assign SRAM_DQ   = (in_access & op_write) ? ((state == HIGH) ? data[31:16] : data[15:0]) : 16'bz;
    assign SRAM_CE_N = 1'b0;
    assign SRAM_UB_N = 1'b0;
    assign SRAM_LB_N = 1'b0;

endmodule
